// File: rtl/correlator_pkg.sv
// rtl/correlator_pkg.sv - shared correlator readout defaults and FSM state type
package correlator_pkg;
    localparam int DEF_DST_WIDTH = 6;
    localparam int DEF_RATE_BITS = 3;
    localparam int DEF_TRATE     = 1 << DEF_RATE_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } readout_state_e;
endpackage

// File: rtl/accum_readout_if.sv
// rtl/accum_readout_if.sv - accumulator storage read/clear port plus sum output stream
interface accum_readout_if
    import correlator_pkg::*;
#(
    parameter int DST_WIDTH = DEF_DST_WIDTH,
    parameter int RATE_BITS = DEF_RATE_BITS
);
    logic                 mem_rd;
    logic                 mem_clr;
    logic [RATE_BITS-1:0] mem_addr;
    logic [DST_WIDTH-1:0] mem_re;
    logic [DST_WIDTH-1:0] mem_im;

    logic                 valid;
    logic                 ready;
    logic [DST_WIDTH-1:0] sum_re;
    logic [DST_WIDTH-1:0] sum_im;
    logic [RATE_BITS-1:0] index;
    logic                 last;

    modport master (
        output mem_rd, mem_clr, mem_addr,
        input  mem_re, mem_im,
        output valid, sum_re, sum_im, index, last,
        input  ready
    );

    modport slave (
        input  mem_rd, mem_clr, mem_addr,
        output mem_re, mem_im,
        input  valid, sum_re, sum_im, index, last,
        output ready
    );
endinterface

// File: rtl/readout_fifo2.sv
// rtl/readout_fifo2.sv - 2-entry registered FIFO; an empty FIFO presents the word being pushed
module readout_fifo2 #(
    parameter int W = 16
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] ent0_q, ent1_q;
    logic [1:0]   count_q;

    assign count_o = count_q;
    assign valid_o = (count_q != 2'd0) || push_i;
    assign head_o  = (count_q == 2'd0 && push_i) ? push_data_i : ent0_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push_i && !pop_i) begin
                        ent0_q  <= push_data_i;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push_i && pop_i) begin
                        ent0_q <= push_data_i;
                    end else if (push_i) begin
                        ent1_q  <= push_data_i;
                        count_q <= 2'd2;
                    end else if (pop_i) begin
                        count_q <= 2'd0;
                    end
                end
                default: begin
                    // Full: the issue throttle upstream never pushes here without a pop.
                    if (pop_i) begin
                        ent0_q <= ent1_q;
                        if (push_i) ent1_q <= push_data_i;
                        else        count_q <= 2'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/accum_readout.sv
// rtl/accum_readout.sv - read-and-clear drain of one accumulator bank onto a valid/ready stream
module accum_readout
    import correlator_pkg::*;
#(
    parameter int DST_WIDTH = DEF_DST_WIDTH,
    parameter int RATE_BITS = DEF_RATE_BITS,
    parameter int TRATE     = 1 << RATE_BITS
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            enable_i,
    input  logic            dump_i,
    output logic            busy_o,
    output logic            overrun_o,
    accum_readout_if.master bus
);
    localparam int EW = 2 * DST_WIDTH + RATE_BITS + 1;
    localparam logic [RATE_BITS-1:0] LAST_ADDR = RATE_BITS'(TRATE - 1);

    readout_state_e       state_q;
    logic                 busy_q, overrun_q;
    logic                 rd_q, rd_dly_q;
    logic [RATE_BITS-1:0] addr_q, idx_dly_q;

    logic          push, pop, fifo_valid, issue_d;
    logic [1:0]    count, count_d;
    logic [EW-1:0] push_data, head_data;

    assign push      = rd_dly_q;
    assign push_data = {bus.mem_re, bus.mem_im, idx_dly_q, idx_dly_q == LAST_ADDR};
    assign pop       = fifo_valid && bus.ready;
    assign count_d   = count + {1'b0, push} - {1'b0, pop};

    // Occupancy after this edge plus the read whose data lands next cycle must stay below 2.
    assign issue_d = (state_q == ST_FETCH) && !(rd_q && addr_q == LAST_ADDR)
                     && ((count_d + {1'b0, rd_q}) < 2'd2);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            rd_q      <= 1'b0;
            rd_dly_q  <= 1'b0;
            addr_q    <= '0;
            idx_dly_q <= '0;
        end else begin
            overrun_q <= dump_i && busy_q;
            rd_dly_q  <= rd_q;
            idx_dly_q <= addr_q;
            case (state_q)
                ST_IDLE: begin
                    if (dump_i && enable_i) begin
                        state_q <= ST_FETCH;
                        busy_q  <= 1'b1;
                        rd_q    <= 1'b1;
                        addr_q  <= '0;
                    end
                end
                ST_FETCH: begin
                    rd_q <= issue_d;
                    if (rd_q && addr_q != LAST_ADDR) addr_q <= addr_q + RATE_BITS'(1);
                    if (rd_q && addr_q == LAST_ADDR) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pop && head_data[0]) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    readout_fifo2 #(.W(EW)) u_fifo (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .valid_o     (fifo_valid),
        .head_o      (head_data),
        .count_o     (count)
    );

    assign busy_o       = busy_q;
    assign overrun_o    = overrun_q;
    assign bus.mem_rd   = rd_q;
    assign bus.mem_clr  = rd_q;
    assign bus.mem_addr = addr_q;
    assign bus.valid    = fifo_valid;
    assign {bus.sum_re, bus.sum_im, bus.index, bus.last} = head_data;
endmodule
